// File: rtl/proc_control_if.sv
`default_nettype none
// ============================================================================
//  Module   : proc_control_if
//  Brief    : Instruction-source and datapath-control signal bundle for
//             proc_control. The master modport is the control unit; the
//             slave modport is the side that supplies Run/DIN and consumes
//             the datapath strobes.
//  Revision : 1.0 - initial release
// ============================================================================
interface proc_control_if #(
    parameter int Tamanho_Da_Palavra = 16,
    parameter int N_REGS             = 8
);
    // Instruction source
    logic                          Run;
    logic [Tamanho_Da_Palavra-1:0] DIN;

    // Datapath control strobes
    logic                          IRin;
    logic [N_REGS-1:0]             Rin;
    logic [N_REGS-1:0]             Rout;
    logic                          temp_io;
    logic                          Gin;
    logic                          Gout;
    logic                          DINout;
    logic                          AddSub;
    logic                          Done;
    logic                          Busy;

    modport master (
        input  Run, DIN,
        output IRin, Rin, Rout, temp_io, Gin, Gout, DINout, AddSub, Done, Busy
    );

    modport slave (
        output Run, DIN,
        input  IRin, Rin, Rout, temp_io, Gin, Gout, DINout, AddSub, Done, Busy
    );
endinterface
`default_nettype wire

// File: rtl/proc_control.sv
`default_nettype none
// ============================================================================
//  Module   : proc_control
//  Brief    : Time-step (T0..T3) control unit for the simple processor
//             datapath. Latches an instruction on Run, then decodes
//             state + IR into bus-select, load-enable and temp strobes,
//             pulsing Done in the final step of each instruction.
//  Revision : 1.0 - initial release
// ============================================================================
module proc_control #(
    parameter int Tamanho_Da_Palavra = 16,
    parameter int N_REGS             = 8
) (
    input  wire logic          Clock,
    input  wire logic          Resetn,
    proc_control_if.master     ctl
);

    // Opcode encodings; 100..111 fall through to the NOP path.
    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    // The three 3-bit fields must fit in the word, and the register
    // fields can only address eight registers.
    if (Tamanho_Da_Palavra < 9) begin : g_bad_width
        $error("proc_control: Tamanho_Da_Palavra must be at least 9");
    end
    if (N_REGS != 8) begin : g_bad_regs
        $error("proc_control: N_REGS must be 8");
    end

    state_t                        state;
    logic [Tamanho_Da_Palavra-1:0] ir;

    logic [2:0] opcode;
    logic [2:0] reg_x;
    logic [2:0] reg_y;
    logic       is_arith;

    assign opcode   = ir[Tamanho_Da_Palavra-1 -: 3];
    assign reg_x    = ir[Tamanho_Da_Palavra-4 -: 3];
    assign reg_y    = ir[Tamanho_Da_Palavra-7 -: 3];
    assign is_arith = (opcode == OP_ADD) || (opcode == OP_SUB);

    // Low IR bits are carried but never decoded.
    if (Tamanho_Da_Palavra > 9) begin : g_unused_bits
        logic unused_ir_bits;
        assign unused_ir_bits = ^ir[Tamanho_Da_Palavra-10:0];
    end

    function automatic logic [N_REGS-1:0] onehot(input logic [2:0] idx);
        logic [N_REGS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Time-step sequencer and instruction latch.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= T0;
            ir    <= '0;
        end else begin
            case (state)
                T0: begin
                    if (ctl.Run) begin
                        ir    <= ctl.DIN;
                        state <= T1;
                    end
                end
                T1:      state <= is_arith ? T2 : T0;
                T2:      state <= is_arith ? T3 : T0;
                default: state <= T0;
            endcase
        end
    end

    logic              irin_c;
    logic [N_REGS-1:0] rin_c;
    logic [N_REGS-1:0] rout_c;
    logic              temp_io_c;
    logic              gin_c;
    logic              gout_c;
    logic              dinout_c;
    logic              addsub_c;
    logic              done_c;
    logic              busy_c;

    // Output decode from the current step and the latched instruction.
    always_comb begin
        irin_c    = 1'b0;
        rin_c     = '0;
        rout_c    = '0;
        temp_io_c = 1'b1;
        gin_c     = 1'b0;
        gout_c    = 1'b0;
        dinout_c  = 1'b0;
        addsub_c  = 1'b0;
        done_c    = 1'b0;
        busy_c    = (state != T0);

        case (state)
            T0: begin
                // Gated by Resetn so a Run seen during reset never strobes IRin.
                irin_c = ctl.Run & Resetn;
            end
            T1: begin
                case (opcode)
                    OP_MV: begin
                        rout_c = onehot(reg_y);
                        rin_c  = onehot(reg_x);
                        done_c = 1'b1;
                    end
                    OP_MVI: begin
                        dinout_c = 1'b1;
                        rin_c    = onehot(reg_x);
                        done_c   = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        rout_c    = onehot(reg_x);
                        temp_io_c = 1'b0;
                    end
                    default: begin
                        done_c = 1'b1;
                    end
                endcase
            end
            T2: begin
                if (is_arith) begin
                    rout_c   = onehot(reg_y);
                    gin_c    = 1'b1;
                    addsub_c = opcode[0];
                end
            end
            default: begin
                if (is_arith) begin
                    gout_c = 1'b1;
                    rin_c  = onehot(reg_x);
                    done_c = 1'b1;
                end
            end
        endcase
    end

    assign ctl.IRin    = irin_c;
    assign ctl.Rin     = rin_c;
    assign ctl.Rout    = rout_c;
    assign ctl.temp_io = temp_io_c;
    assign ctl.Gin     = gin_c;
    assign ctl.Gout    = gout_c;
    assign ctl.DINout  = dinout_c;
    assign ctl.AddSub  = addsub_c;
    assign ctl.Done    = done_c;
    assign ctl.Busy    = busy_c;

endmodule
`default_nettype wire

// File: tb/tb_proc_control.sv
`default_nettype none
// ============================================================================
//  Module   : tb_proc_control
//  Brief    : Self-checking bench for proc_control: directed vector table,
//             reset/abort sequences and a random Run/DIN sweep, with a
//             small register-file/ALU model fed from the control strobes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_proc_control;

    logic Clock = 1'b0;
    logic Resetn;

    proc_control_if #(.Tamanho_Da_Palavra(16), .N_REGS(8)) pif ();

    proc_control #(.Tamanho_Da_Palavra(16), .N_REGS(8)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .ctl    (pif)
    );

    always #5 Clock = ~Clock;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- datapath model ----------------
    logic [15:0] mr [8];
    logic [15:0] ma;
    logic [15:0] mg;
    logic        preload;

    // Register file, A and G driven purely by the observed control strobes.
    always @(posedge Clock) begin : model
        logic [15:0] bus_v;
        bus_v = 16'h0;
        for (int k = 0; k < 8; k++) if (pif.Rout[k]) bus_v = mr[k];
        if (pif.Gout)   bus_v = mg;
        if (pif.DINout) bus_v = pif.DIN;
        if (preload) begin
            for (int k = 0; k < 8; k++) mr[k] <= 16'h0;
            mr[1] <= 16'd7;
            mr[2] <= 16'd5;
            ma    <= 16'h0;
            mg    <= 16'h0;
        end else begin
            for (int k = 0; k < 8; k++) if (pif.Rin[k]) mr[k] <= bus_v;
            if (!pif.temp_io) ma <= bus_v;
            if (pif.Gin) mg <= pif.AddSub ? (ma - bus_v) : (ma + bus_v);
        end
    end

    // ---------------- helpers ----------------
    // Packing: {IRin, Rin, Rout, temp_io, Gin, Gout, DINout, AddSub, Done, Busy}
    function automatic logic [23:0] E(input logic irin, input logic [7:0] rin,
                                      input logic [7:0] rout, input logic tio,
                                      input logic gin, input logic gout,
                                      input logic dinout, input logic addsub,
                                      input logic done, input logic busy);
        return {irin, rin, rout, tio, gin, gout, dinout, addsub, done, busy};
    endfunction

    function automatic logic [23:0] outs();
        return {pif.IRin, pif.Rin, pif.Rout, pif.temp_io, pif.Gin, pif.Gout,
                pif.DINout, pif.AddSub, pif.Done, pif.Busy};
    endfunction

    task automatic check_out(input string name, input logic [23:0] exp);
        logic [23:0] got;
        got = outs();
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: outputs got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_reg(input string name, input int idx, input logic [15:0] exp);
        n_vec++;
        if (mr[idx] !== exp) begin
            n_err++;
            $display("FAIL %s: R%0d got %h expected %h", name, idx, mr[idx], exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        run;
        logic [15:0] din;
        logic [23:0] exp;
        logic        chk;
        int          ridx;
        logic [15:0] rval;
    } vec_t;

    localparam int NV = 21;
    vec_t tbl [NV];

    initial begin
        logic [23:0] idle, ldir;
        int started, pend, cyc;
        logic ex_irin, ex_done, ex_busy;

        idle = E(0, 8'h00, 8'h00, 1, 0, 0, 0, 0, 0, 0);
        ldir = E(1, 8'h00, 8'h00, 1, 0, 0, 0, 0, 0, 0);

        //            run   din      expected outputs                                   chk ridx rval
        tbl[0]  = '{1'b0, 16'h0000, idle,                                               0, 0, 16'h0000};
        tbl[1]  = '{1'b1, 16'h2C00, ldir,                                               0, 0, 16'h0000}; // mvi R3
        tbl[2]  = '{1'b0, 16'h00A5, E(0, 8'h08, 8'h00, 1, 0, 0, 1, 0, 1, 1),            0, 0, 16'h0000};
        tbl[3]  = '{1'b1, 16'h4500, ldir,                                               1, 3, 16'h00A5}; // add R1,R2
        tbl[4]  = '{1'b0, 16'h0000, E(0, 8'h00, 8'h02, 0, 0, 0, 0, 0, 0, 1),            0, 0, 16'h0000};
        tbl[5]  = '{1'b1, 16'h2000, E(0, 8'h00, 8'h04, 1, 1, 0, 0, 0, 0, 1),            0, 0, 16'h0000}; // Run in T2 ignored
        tbl[6]  = '{1'b0, 16'h0000, E(0, 8'h02, 8'h00, 1, 0, 1, 0, 0, 1, 1),            0, 0, 16'h0000};
        tbl[7]  = '{1'b1, 16'h6500, ldir,                                               1, 1, 16'h000C}; // sub R1,R2
        tbl[8]  = '{1'b0, 16'h0000, E(0, 8'h00, 8'h02, 0, 0, 0, 0, 0, 0, 1),            0, 0, 16'h0000};
        tbl[9]  = '{1'b0, 16'h0000, E(0, 8'h00, 8'h04, 1, 1, 0, 0, 1, 0, 1),            0, 0, 16'h0000};
        tbl[10] = '{1'b0, 16'h0000, E(0, 8'h02, 8'h00, 1, 0, 1, 0, 0, 1, 1),            0, 0, 16'h0000};
        tbl[11] = '{1'b1, 16'h0080, ldir,                                               1, 1, 16'h0007}; // mv R0,R1
        tbl[12] = '{1'b1, 16'hE000, E(0, 8'h01, 8'h02, 1, 0, 0, 0, 0, 1, 1),            0, 0, 16'h0000};
        tbl[13] = '{1'b1, 16'hE000, ldir,                                               1, 0, 16'h0007}; // NOP
        tbl[14] = '{1'b1, 16'h497F, E(0, 8'h00, 8'h00, 1, 0, 0, 0, 0, 1, 1),            0, 0, 16'h0000};
        tbl[15] = '{1'b1, 16'h497F, ldir,                                               0, 0, 16'h0000}; // add R2,R2
        tbl[16] = '{1'b0, 16'h0000, E(0, 8'h00, 8'h04, 0, 0, 0, 0, 0, 0, 1),            0, 0, 16'h0000};
        tbl[17] = '{1'b0, 16'h0000, E(0, 8'h00, 8'h04, 1, 1, 0, 0, 0, 0, 1),            0, 0, 16'h0000};
        tbl[18] = '{1'b0, 16'h0000, E(0, 8'h04, 8'h00, 1, 0, 1, 0, 0, 1, 1),            0, 0, 16'h0000};
        tbl[19] = '{1'b0, 16'hFFFF, idle,                                               1, 2, 16'h000A};
        tbl[20] = '{1'b0, 16'hFFFF, idle,                                               0, 0, 16'h0000};

        // ---- reset: Run pulsed while held in reset ----
        Resetn   = 1'b0;
        preload  = 1'b1;
        pif.Run  = 1'b0;
        pif.DIN  = 16'h0000;
        repeat (2) @(negedge Clock);
        preload  = 1'b0;
        pif.Run  = 1'b1;
        pif.DIN  = 16'h2000;
        #1 check_out("reset_run_pulse", idle);
        @(negedge Clock);
        #1 check_out("reset_after_edge", idle);
        pif.Run  = 1'b0;
        Resetn   = 1'b1;
        @(negedge Clock);
        #1 check_out("post_reset_idle", idle);

        // ---- directed table ----
        for (int i = 0; i < NV; i++) begin
            @(negedge Clock);
            pif.Run = tbl[i].run;
            pif.DIN = tbl[i].din;
            #1;
            check_out($sformatf("vec%0d", i), tbl[i].exp);
            if (tbl[i].chk) check_reg($sformatf("vec%0d_reg", i), tbl[i].ridx, tbl[i].rval);
        end

        // ---- reset abort during T2 of add R1,R2 (R1=7, R2=10) ----
        @(negedge Clock);
        pif.Run = 1'b1;
        pif.DIN = 16'h4500;
        #1 check_out("abort_load", ldir);
        @(negedge Clock);
        pif.Run = 1'b0;
        #1 check_out("abort_t1", E(0, 8'h00, 8'h02, 0, 0, 0, 0, 0, 0, 1));
        @(negedge Clock);
        #1 check_out("abort_t2", E(0, 8'h00, 8'h04, 1, 1, 0, 0, 0, 0, 1));
        Resetn = 1'b0;
        #1 check_out("abort_cleared", idle);
        repeat (2) @(negedge Clock);
        #1 check_out("abort_held", idle);
        check_reg("abort_no_write", 1, 16'h0007);

        // Release coincident with Run: first edge must take the instruction.
        pif.Run = 1'b1;
        pif.DIN = 16'h0080;
        Resetn  = 1'b1;
        #1 check_out("release_with_run", ldir);
        @(negedge Clock);
        pif.Run = 1'b0;
        #1 check_out("release_mv_t1", E(0, 8'h01, 8'h02, 1, 0, 0, 0, 0, 1, 1));
        @(negedge Clock);
        #1 check_out("release_idle", idle);
        check_reg("release_mv_r0", 0, 16'h0007);

        // ---- random sweep: exclusivity and Done/Busy timing ----
        started = 0;
        pend    = 0;
        cyc     = 0;
        while (started < 200 && cyc < 3000) begin
            @(negedge Clock);
            cyc++;
            pif.Run = ($urandom_range(0, 3) != 0);
            pif.DIN = 16'($urandom);
            #1;
            n_vec++;
            if (!$onehot0(pif.Rin) || !$onehot0(pif.Rout) ||
                (($countones(pif.Rout) + int'(pif.Gout) + int'(pif.DINout)) > 1)) begin
                n_err++;
                $display("FAIL rand_bus cyc%0d: Rin %b Rout %b Gout %b DINout %b required one-hot and single driver",
                         cyc, pif.Rin, pif.Rout, pif.Gout, pif.DINout);
            end
            if (pend > 0) begin
                pend--;
                ex_irin = 1'b0;
                ex_busy = 1'b1;
                ex_done = (pend == 0);
            end else begin
                ex_irin = pif.Run;
                ex_busy = 1'b0;
                ex_done = 1'b0;
                if (pif.Run) begin
                    started++;
                    pend = (pif.DIN[15:14] == 2'b01) ? 3 : 1;
                end
            end
            n_vec++;
            if ({pif.IRin, pif.Done, pif.Busy} !== {ex_irin, ex_done, ex_busy}) begin
                n_err++;
                $display("FAIL rand_timing cyc%0d: IRin/Done/Busy got %b expected %b",
                         cyc, {pif.IRin, pif.Done, pif.Busy}, {ex_irin, ex_done, ex_busy});
            end
        end
        if (started < 200) begin
            n_err++;
            $display("FAIL rand_budget: started %0d instructions, expected 200", started);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
